// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and line constants,
// common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 5208;
  localparam logic        UART_IDLE_LEVEL           = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and pulses tick_o on the terminal count.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] count_q, count_d;

  assign tick_o = (count_q == LastCnt);

  always_comb begin
    count_d = count_q + CntW'(1);
    if (clear_i || tick_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: accepts a byte while idle and shifts it out LSB first with
// registered line and status outputs.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic       UART_TXD
);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        txd_q, txd_d;
  logic        status_q, status_d;
  logic        timer_clear;
  logic        tick;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i  (sysclk),
    .rst_ni (reset),
    .clear_i(timer_clear),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    timer_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Timer held at zero so the start bit gets a full period after accept.
        timer_clear = 1'b1;
        if (TX_EN) begin
          shift_d = TX_DATA;
          idx_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (tick) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs derive from the current state, giving one cycle of accept-to-line latency.
  always_comb begin
    txd_d    = UART_IDLE_LEVEL;
    status_d = (state_q == StIdle);
    unique case (state_q)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_q[0];
      default: txd_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      shift_q  <= 8'h00;
      idx_q    <= '0;
      txd_q    <= UART_IDLE_LEVEL;
      status_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      txd_q    <= txd_d;
      status_q <= status_d;
    end
  end

  assign UART_TXD  = txd_q;
  assign TX_STATUS = status_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at 16 clocks per bit; cycle 0 is the accept edge.
module tb_uart_transmitter;

  localparam int unsigned N = 16;

  logic       sysclk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_status;
  logic       uart_txd;

  int checks = 0;
  int errors = 0;

  uart_transmitter #(
    .CLKS_PER_BIT(N)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .TX_DATA  (tx_data),
    .TX_EN    (tx_en),
    .TX_STATUS(tx_status),
    .UART_TXD (uart_txd)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame: samples mid-bit (8+16k), counts busy cycles and any low level after the stop bit.
  task automatic frame(input logic [7:0] data, input logic [7:0] data_c1, input int en_at,
                       output logic [9:0] bits, output int busy, output int late_low);
    bits     = '0;
    busy     = 0;
    late_low = 0;
    tx_data  = data;
    tx_en    = 1'b1;
    step();
    tx_en = 1'b0;
    for (int c = 1; c <= 180; c++) begin
      step();
      if (c == 1) tx_data = data_c1;
      if (en_at != 0 && c == en_at) tx_en = 1'b1;
      if (en_at != 0 && c == en_at + 1) tx_en = 1'b0;
      if (c % 16 == 8 && c < 160) bits[c/16] = uart_txd;
      if (tx_status !== 1'b1) busy++;
      if (c > 160 && uart_txd !== 1'b1) late_low++;
    end
  endtask

  logic [9:0] bits, b0, b1;
  int busy, late_low, toggles, first_fall;
  logic prev;

  initial begin
    reset   = 1'b0;
    tx_en   = 1'b0;
    tx_data = 8'h00;

    // Reset held with TX_EN toggling.
    for (int i = 0; i < 5; i++) begin
      tx_en = 1'(i % 2);
      step();
      check("rst_txd", 16'(uart_txd), 16'd1);
      check("rst_status", 16'(tx_status), 16'd1);
    end
    tx_en = 1'b0;
    reset = 1'b1;
    prev    = uart_txd;
    toggles = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (uart_txd !== prev) toggles++;
      prev = uart_txd;
    end
    check("quiet_after_rst", 16'(toggles), 16'd0);

    // 0x55: 0,1,0,1,0,1,0,1,0,1 from bit 0 (start) upward.
    frame(8'h55, 8'h55, 0, bits, busy, late_low);
    check("bits_55", 16'(bits), 16'h02AA);
    check("busy_55", 16'(busy), 16'd160);
    check("idle_after_55", 16'(late_low), 16'd0);

    // 0xA3 with TX_DATA switched to 0xFF at cycle 1.
    frame(8'hA3, 8'hFF, 0, bits, busy, late_low);
    check("bits_a3", 16'(bits), 16'h0346);

    // Request of 0x12 at cycle 50 while 0x34 is in flight.
    frame(8'h34, 8'h12, 50, bits, busy, late_low);
    check("bits_34", 16'(bits), 16'h0268);
    check("busy_34", 16'(busy), 16'd160);
    check("idle_after_34", 16'(late_low), 16'd0);

    // Back-to-back with TX_EN held: second frame accepted at edge 161, start at 162.
    repeat (5) step();
    b0         = '0;
    b1         = '0;
    first_fall = 0;
    tx_data    = 8'h0F;
    tx_en      = 1'b1;
    step();
    for (int c = 1; c <= 340; c++) begin
      step();
      if (c == 1) tx_data = 8'hF0;
      if (c == 161) tx_en = 1'b0;
      if (c > 160 && first_fall == 0 && uart_txd === 1'b0) first_fall = c;
      if (c % 16 == 8 && c < 160) b0[c/16] = uart_txd;
      if (c >= 169 && (c - 169) % 16 == 0 && (c - 169) / 16 < 10) b1[(c-169)/16] = uart_txd;
    end
    check("b2b_second_start", 16'(first_fall), 16'd162);
    check("rx_data_0", 16'(b0[8:1]), 16'h000F);
    check("rx_frame_0", 16'(b0), 16'h021E);
    check("rx_data_1", 16'(b1[8:1]), 16'h00F0);
    check("rx_frame_1", 16'(b1), 16'h03E0);

    // Reset at cycle 70 of a 0x00 frame (line low during data bits).
    repeat (5) step();
    tx_data = 8'h00;
    tx_en   = 1'b1;
    step();
    tx_en = 1'b0;
    repeat (70) step();
    check("pre_rst_txd", 16'(uart_txd), 16'd0);
    reset = 1'b0;
    #1;
    check("midrst_txd", 16'(uart_txd), 16'd1);
    check("midrst_status", 16'(tx_status), 16'd1);
    repeat (3) step();
    reset   = 1'b1;
    toggles = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (uart_txd !== 1'b1 || tx_status !== 1'b1) toggles++;
    end
    check("no_retransmit", 16'(toggles), 16'd0);

    frame(8'h81, 8'h81, 0, bits, busy, late_low);
    check("bits_81", 16'(bits), 16'h0302);
    check("busy_81", 16'(busy), 16'd160);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit half of the UART link: accepts one byte per handshake from the host logic and shifts it out on `UART_TXD` as an 8N1 frame (1 start bit, 8 data bits LSB first, 1 stop bit). It pairs with `UART_Receiver` on the opposite line and shares its byte-plus-status style of interface. Bit timing is generated internally from `sysclk` by a terminal-count divider, so no external baud clock is needed.

## Interface
- `CLKS_PER_BIT`, 5208, `sysclk` cycles per serial bit (50 MHz / 9600 baud); legal range ≥ 2
- `sysclk`  input  1  system clock; all state updates on the rising edge
- `reset`  input  1  asynchronous, active-low reset
- `TX_DATA`  input  8  byte to send; sampled only on the accept cycle
- `TX_EN`  input  1  send request; level-sensitive, honoured only while `TX_STATUS`=1
- `TX_STATUS`  output  1  1 = idle and ready to accept; 0 = frame in progress
- `UART_TXD`  output  1  serial line; idles high

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `UART_TXD`=1, `TX_STATUS`=1.
  - If `TX_EN`=1 at an edge: latch `TX_DATA` into the shift register, clear the bit counter, go to START.
- START:
  - `UART_TXD`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA:
  - `UART_TXD` = shift register bit 0, held for `CLKS_PER_BIT` cycles.
  - Then shift right and increment the index.
  - After index 7 completes, go to STOP.
- STOP:
  - `UART_TXD`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- `TX_STATUS` is 0 in START, DATA and STOP.
- `TX_EN` outside IDLE is ignored. It is not queued.
- `TX_DATA` changes after the accept cycle do not affect the frame in progress.
- Bit counter:
  - Width is `$clog2(CLKS_PER_BIT)`.
  - Counts 0 to `CLKS_PER_BIT`-1 and wraps to 0 at the terminal count, which advances the state.
- Index counter: 3 bits.
- All outputs are registered, so `UART_TXD` never glitches.

## Timing
- Reset (asynchronous, while `reset`=0): state IDLE, `UART_TXD`=1, `TX_STATUS`=1, counters 0, shift register 0x00.
- Reset asserted mid-frame:
  - The line returns high immediately and the frame is abandoned.
  - No partial retransmission after `reset` returns high.
- Frame cycle counts, with accept edge = cycle 0 and N = `CLKS_PER_BIT`:
  - Cycles 1..N: `UART_TXD`=0 (start bit); `TX_STATUS`=0 from cycle 1.
  - Data bit k occupies cycles (k+1)N+1 .. (k+2)N.
  - Stop bit occupies cycles 9N+1 .. 10N.
  - `TX_STATUS`=1 again at cycle 10N+1.
- Back-to-back:
  - If `TX_EN`=1 during the first IDLE cycle (10N+1), the next start bit begins at cycle 10N+2.
  - Minimum inter-frame idle is 1 `sysclk` cycle in addition to the full stop bit.
- `TX_EN` and `reset` deasserting on the same edge: reset wins, and no frame starts on that edge.
- Latency from accept to the start bit on the line: 1 cycle.

## Structure
- Shared package `uart_pkg`:
  - State encoding (IDLE/START/DATA/STOP).
  - `UART_DATA_BITS`=8.
  - Default `CLKS_PER_BIT`.
  - Idle-line level constant.
  - `UART_Receiver` uses the same package.
- One natural sub-module: `uart_bit_timer`.
  - A parameterised `CLKS_PER_BIT` counter with clear input and a one-cycle `tick` output at the terminal count.
  - Reusable by the receiver.
- FSM, shift register and index counter stay in `uart_transmitter`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Reset values: `reset`=0 for 5 cycles, with `TX_EN` toggling.
  - Required: `UART_TXD`=1 and `TX_STATUS`=1 throughout.
  - Required: no transition on `UART_TXD` after release.
- Single byte 0x55: pulse `TX_EN` for 1 cycle.
  - Required: sampling at mid-bit (cycle 8+16k) yields 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop).
  - Required: `TX_STATUS`=0 for exactly 160 cycles.
- Byte 0xA3 with `TX_DATA` changed to 0xFF on cycle 1.
  - Required: data bits on the line are 1,1,0,0,0,1,0,1 (0xA3, not 0xFF).
- Busy request: pulse `TX_EN` with 0x12 at cycle 50 of a frame carrying 0x34.
  - Required: only 0x34 is transmitted.
  - Required: the line stays idle after the stop bit.
- Back-to-back: hold `TX_EN`=1 with 0x0F, then 0xF0.
  - Required: the second start bit falls at cycle 162.
  - Required: both bytes decode correctly in a loopback into `UART_Receiver`, with `RX_DATA`=0x0F then 0xF0.
- Reset mid-frame: assert `reset` at cycle 70 of a frame.
  - Required: `UART_TXD`=1 in the same cycle and `TX_STATUS`=1.
  - Required: a new 0x81 request after release transmits a clean frame.
